// File: rtl/port_stat_collector_pkg.sv
// Shared constants, stat-kind indices and FSM encoding for the port statistics
// collector and its counters.
package port_stat_collector_pkg;

  localparam int         REG_WIDTH      = 16;
  localparam logic [6:0] STAT_BASE_ADDR = 7'h10;

  localparam int KIND_RX   = 0;
  localparam int KIND_TX   = 1;
  localparam int KIND_ER   = 2;
  localparam int NUM_KINDS = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/port_stat_collector_stat_counter.sv
// One saturating event counter with a dirty flag marking a value that has not
// yet been pushed to the register table.
module stat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_clr,
  input  logic                 i_dirty_clr,
  output logic [CNT_WIDTH-1:0] o_value,
  output logic                 o_dirty
);

  logic [CNT_WIDTH-1:0] r_value;
  logic                 r_dirty;

  // Clear beats increment, and both beat the dirty-clear from a write in flight,
  // so a value changed during its own write is written again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_value <= '0;
      r_dirty <= 1'b0;
    end else if (i_clr) begin
      r_value <= '0;
      r_dirty <= 1'b1;
    end else if (i_inc) begin
      if (r_value != '1) r_value <= r_value + CNT_WIDTH'(1);
      r_dirty <= 1'b1;
    end else if (i_dirty_clr) begin
      r_dirty <= 1'b0;
    end
  end

  assign o_value = r_value;
  assign o_dirty = r_dirty;

endmodule

// File: rtl/port_stat_collector.sv
// Counts per-port RX/TX/error events and pushes changed counts round-robin into
// the statistics registers over the internal write bus.
module port_stat_collector
  import port_stat_collector_pkg::*;
#(
  parameter int         NUM_PORTS      = 4,
  parameter int         CNT_WIDTH      = port_stat_collector_pkg::REG_WIDTH,
  parameter logic [6:0] STAT_BASE_ADDR = port_stat_collector_pkg::STAT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] rx_pulse,
  input  logic [NUM_PORTS-1:0] tx_pulse,
  input  logic [NUM_PORTS-1:0] err_pulse,
  input  logic                 stat_clear,
  input  logic                 bus_gnt,
  output logic                 bus_req,
  output logic [6:0]           addr,
  output logic                 wr,
  output logic [CNT_WIDTH-1:0] din,
  output logic [1:0]           o_dbg_state
);

  localparam int NUM_CNT = NUM_KINDS * NUM_PORTS;
  localparam int IDX_W   = $clog2(NUM_CNT);

  // Bus handshake: bus_req rises on leaving IDLE and stays high until the
  // single-cycle write completes; a grant observed in REQ moves to WRITE, and
  // the write finishes even if the grant is withdrawn during it.
  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_sel;
  logic [IDX_W-1:0]     w_sel_nxt;
  logic [IDX_W-1:0]     r_ptr;
  logic [IDX_W-1:0]     w_ptr_nxt;

  logic [NUM_CNT-1:0]   w_evt;
  logic [NUM_CNT-1:0]   w_dclr;
  logic [NUM_CNT-1:0]   w_dirty;
  logic [CNT_WIDTH-1:0] w_cnt [NUM_CNT];

  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic [IDX_W:0]       w_idx;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign w_evt[NUM_KINDS*p + KIND_RX] = rx_pulse[p];
    assign w_evt[NUM_KINDS*p + KIND_TX] = tx_pulse[p];
    assign w_evt[NUM_KINDS*p + KIND_ER] = err_pulse[p];
  end

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_cnt
    assign w_dclr[i] = (r_state == ST_WRITE) && (r_sel == IDX_W'(i));

    stat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_inc      (w_evt[i]),
      .i_clr      (stat_clear),
      .i_dirty_clr(w_dclr[i]),
      .o_value    (w_cnt[i]),
      .o_dirty    (w_dirty[i])
    );
  end

  // First dirty counter at or after the scan pointer, wrapping around the table.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int j = 0; j < NUM_CNT; j++) begin
      w_idx = {1'b0, r_ptr} + (IDX_W+1)'(j);
      if (w_idx >= (IDX_W+1)'(NUM_CNT)) w_idx = w_idx - (IDX_W+1)'(NUM_CNT);
      if (!w_found && w_dirty[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_gnt) w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        w_ptr_nxt   = (r_sel == IDX_W'(NUM_CNT - 1)) ? '0 : r_sel + IDX_W'(1);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so an asynchronous reset drops them at once.
  assign bus_req     = (r_state == ST_REQ) || (r_state == ST_WRITE);
  assign wr          = (r_state == ST_WRITE);
  assign addr        = wr ? (STAT_BASE_ADDR + 7'(r_sel)) : 7'd0;
  assign din         = wr ? w_cnt[r_sel] : '0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_port_stat_collector.sv
// Directed bench for port_stat_collector: every write on the bus is logged and
// each scenario compares the log against hand-computed addresses and data.
module tb_port_stat_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  rx_pulse = '0;
  logic [3:0]  tx_pulse = '0;
  logic [3:0]  err_pulse = '0;
  logic        stat_clear = 1'b0;
  logic        bus_gnt = 1'b0;
  logic        bus_req;
  logic [6:0]  addr;
  logic        wr;
  logic [15:0] din;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0]  got_addr_q[$];
  logic [15:0] got_din_q[$];

  always #5 clk = ~clk;

  port_stat_collector dut (
    .clk        (clk),
    .rst        (rst),
    .rx_pulse   (rx_pulse),
    .tx_pulse   (tx_pulse),
    .err_pulse  (err_pulse),
    .stat_clear (stat_clear),
    .bus_gnt    (bus_gnt),
    .bus_req    (bus_req),
    .addr       (addr),
    .wr         (wr),
    .din        (din),
    .o_dbg_state(dbg_state)
  );

  always @(negedge clk) begin
    if (wr === 1'b1) begin
      got_addr_q.push_back(addr);
      got_din_q.push_back(din);
      n_checks++;
      if (bus_req !== 1'b1) begin
        n_errors++;
        $display("FAIL wr_without_req: bus_req=%b while wr=1, required 1", bus_req);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic clear_log();
    got_addr_q.delete();
    got_din_q.delete();
  endtask

  task automatic test_reset();
    logic bad;
    bus_gnt = 1'b1;
    #3;
    n_checks++;
    if ({bus_req, wr, addr, din} !== 25'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: req=%b wr=%b addr=%h din=%h, required all 0", bus_req, wr, addr, din);
    end
    step();
    rst = 1'b1;
    bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if ({bus_req, wr, addr, din} !== 25'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL idle_quiet: outputs left 0 while idle with grant high, required all 0");
    end
    n_checks++;
    if (got_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL idle_no_writes: %0d writes, required 0", got_addr_q.size());
    end
  endtask

  task automatic test_single_write();
    clear_log();
    step();
    rx_pulse = 4'b0100;
    step();
    rx_pulse = '0;
    run(20);
    n_checks++;
    if (got_addr_q.size() != 1) begin
      n_errors++;
      $display("FAIL single_count: %0d writes, required 1", got_addr_q.size());
    end
    n_checks++;
    if (got_addr_q.size() < 1 || got_addr_q[0] !== 7'h16) begin
      n_errors++;
      $display("FAIL single_addr: addr=%h, required 16", got_addr_q.size() ? got_addr_q[0] : 7'h7f);
    end
    n_checks++;
    if (got_din_q.size() < 1 || got_din_q[0] !== 16'h0001) begin
      n_errors++;
      $display("FAIL single_din: din=%h, required 0001", got_din_q.size() ? got_din_q[0] : 16'hdead);
    end
  endtask

  task automatic test_grant_stall();
    logic bad;
    clear_log();
    bus_gnt = 1'b0;
    step();
    tx_pulse = 4'b0001;
    run(3);
    tx_pulse = '0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_req !== 1'b1 || wr !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL stall_req_held: bus_req/wr not 1/0 during grant stall, required 1/0");
    end
    @(posedge clk);
    #1;
    bus_gnt = 1'b1;
    step();
    n_checks++;
    if (wr !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_write_cycle: wr=%b one cycle after grant, required 1", wr);
    end
    tx_pulse = 4'b0001;
    bus_gnt  = 1'b0;
    step();
    tx_pulse = '0;
    bus_gnt  = 1'b1;
    run(15);
    n_checks++;
    if (got_addr_q.size() != 2) begin
      n_errors++;
      $display("FAIL stall_count: %0d writes, required 2", got_addr_q.size());
    end
    n_checks++;
    if (got_addr_q.size() < 2 || got_addr_q[0] !== 7'h11 || got_din_q[0] !== 16'h0003) begin
      n_errors++;
      $display("FAIL stall_first: addr=%h din=%h, required 11/0003",
               got_addr_q.size() ? got_addr_q[0] : 7'h7f, got_din_q.size() ? got_din_q[0] : 16'hdead);
    end
    n_checks++;
    if (got_addr_q.size() < 2 || got_addr_q[1] !== 7'h11 || got_din_q[1] !== 16'h0004) begin
      n_errors++;
      $display("FAIL stall_second: addr=%h din=%h, required 11/0004",
               got_addr_q.size() > 1 ? got_addr_q[1] : 7'h7f, got_din_q.size() > 1 ? got_din_q[1] : 16'hdead);
    end
  endtask

  task automatic test_saturation();
    logic bad;
    clear_log();
    bus_gnt   = 1'b1;
    err_pulse = 4'b1000;
    run(65534);
    err_pulse = '0;
    run(10);
    n_checks++;
    if (got_addr_q.size() < 1 || got_addr_q[$] !== 7'h1B || got_din_q[$] !== 16'hFFFE) begin
      n_errors++;
      $display("FAIL sat_preload: last addr=%h din=%h, required 1b/fffe",
               got_addr_q.size() ? got_addr_q[$] : 7'h7f, got_din_q.size() ? got_din_q[$] : 16'hdead);
    end
    clear_log();
    repeat (3) begin
      err_pulse = 4'b1000;
      step();
      err_pulse = '0;
      step();
    end
    run(10);
    bad = (got_din_q.size() < 1);
    foreach (got_din_q[i]) if (got_din_q[i] !== 16'hFFFF || got_addr_q[i] !== 7'h1B) bad = 1'b1;
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL sat_hold: %0d writes, last din=%h, required all 1b/ffff",
               got_din_q.size(), got_din_q.size() ? got_din_q[$] : 16'hdead);
    end
  endtask

  task automatic test_clear_plus_event();
    logic bad_addr;
    logic bad_din;
    clear_log();
    stat_clear = 1'b1;
    rx_pulse   = 4'b0010;
    step();
    stat_clear = 1'b0;
    rx_pulse   = '0;
    run(50);
    n_checks++;
    if (got_addr_q.size() != 12) begin
      n_errors++;
      $display("FAIL clear_count: %0d writes, required 12", got_addr_q.size());
    end
    bad_addr = 1'b0;
    bad_din  = 1'b0;
    foreach (got_addr_q[i]) begin
      if (got_addr_q[i] !== 7'(7'h10 + i)) bad_addr = 1'b1;
      if (got_din_q[i] !== 16'h0000) bad_din = 1'b1;
    end
    n_checks++;
    if (bad_addr) begin
      n_errors++;
      $display("FAIL clear_order: first addr=%h, required 10..1b in order",
               got_addr_q.size() ? got_addr_q[0] : 7'h7f);
    end
    n_checks++;
    if (bad_din) begin
      n_errors++;
      $display("FAIL clear_zero: a cleared write carried nonzero data, required 0000");
    end
  endtask

  task automatic test_fairness();
    int pos_1b;
    int n_1b;
    clear_log();
    rx_pulse  = 4'b0001;
    err_pulse = 4'b1000;
    step();
    err_pulse = '0;
    run(40);
    rx_pulse = '0;
    run(10);
    pos_1b = -1;
    n_1b   = 0;
    foreach (got_addr_q[i]) begin
      if (got_addr_q[i] === 7'h1B) begin
        if (pos_1b < 0) pos_1b = i;
        n_1b++;
      end
    end
    n_checks++;
    if (pos_1b < 0 || pos_1b >= 12) begin
      n_errors++;
      $display("FAIL fair_latency: addr 1b at write %0d, required within 12", pos_1b);
    end
    n_checks++;
    if (n_1b != 1 || got_din_q[pos_1b < 0 ? 0 : pos_1b] !== 16'h0001) begin
      n_errors++;
      $display("FAIL fair_err_write: %0d writes to 1b, required exactly one with din 0001", n_1b);
    end
    n_checks++;
    if (got_addr_q.size() < 1 || got_addr_q[0] !== 7'h10) begin
      n_errors++;
      $display("FAIL fair_first: first addr=%h, required 10", got_addr_q.size() ? got_addr_q[0] : 7'h7f);
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    bus_gnt  = 1'b0;
    tx_pulse = 4'b0010;
    step();
    tx_pulse = '0;
    run(2);
    n_checks++;
    if (bus_req !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_req_up: bus_req=%b, required 1", bus_req);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus_req !== 1'b0 || wr !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_req_drop: bus_req=%b wr=%b after async reset, required 0/0", bus_req, wr);
    end
    step();
    rst     = 1'b1;
    bus_gnt = 1'b1;
    tx_pulse = 4'b0010;
    step();
    tx_pulse = '0;
    run(2);
    n_checks++;
    if (wr !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_write_up: wr=%b, required 1", wr);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (wr !== 1'b0 || addr !== 7'd0 || din !== 16'd0) begin
      n_errors++;
      $display("FAIL mid_write_drop: wr=%b addr=%h din=%h after async reset, required 0", wr, addr, din);
    end
    step();
    rst = 1'b1;
    run(10);
    n_checks++;
    if (got_addr_q.size() != 0) begin
      n_errors++;
      $display("FAIL mid_no_retry: %0d writes after reset, required 0", got_addr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_grant_stall();
    test_saturation();
    test_clear_plus_event();
    test_fairness();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
